// File: rtl/mmio_arbiter_if.sv
// Signal bundle between the two MMIO masters, the arbiter and the mmio_sys
// bus port. The arbiter uses the slave view. The masters and the bus slot use
// the master view. The m0_lock/m1_lock wires exist only when MMIO_ARB_LOCK_EN
// is defined.
interface mmio_arbiter_if;
  logic        m0_req,     m1_req;
  logic        m0_wr,      m1_wr;
  logic [20:0] m0_addr,    m1_addr;
  logic [31:0] m0_wr_data, m1_wr_data;
`ifdef MMIO_ARB_LOCK_EN
  logic        m0_lock,    m1_lock;
`endif
  logic        m0_ack,     m1_ack;
  logic [31:0] m0_rd_data, m1_rd_data;
  logic        busy;
  logic        mmio_cs, mmio_wr, mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data;
  logic [31:0] mmio_rd_data;

`ifdef MMIO_ARB_LOCK_EN
  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr,
           m0_wr_data, m1_wr_data, m0_lock, m1_lock, mmio_rd_data,
    output m0_ack, m1_ack, m0_rd_data, m1_rd_data, busy,
           mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
  );
  modport master (
    output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr,
           m0_wr_data, m1_wr_data, m0_lock, m1_lock, mmio_rd_data,
    input  m0_ack, m1_ack, m0_rd_data, m1_rd_data, busy,
           mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
  );
`else
  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr,
           m0_wr_data, m1_wr_data, mmio_rd_data,
    output m0_ack, m1_ack, m0_rd_data, m1_rd_data, busy,
           mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
  );
  modport master (
    output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr,
           m0_wr_data, m1_wr_data, mmio_rd_data,
    input  m0_ack, m1_ack, m0_rd_data, m1_rd_data, busy,
           mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
  );
`endif
endinterface

// File: rtl/mmio_arbiter.sv
// Two-master round-robin arbiter in front of the single-word MMIO bus.
// Each transaction takes three cycles: IDLE (grant) -> ISSUE (one-cycle bus
// strobe, read data captured) -> ACK (one-cycle ack to the owner).
// Optional feature: define MMIO_ARB_LOCK_EN to add m0_lock/m1_lock. A master
// that holds lock through its ACK keeps the bus for its next request.
module mmio_arbiter (
  input  logic           clk,
  input  logic           reset,
  mmio_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

  state_t      state, state_nxt;
  logic        grant;
  logic        win, rr_win;
  logic        owner, last;
  logic        wr_q;
  logic [20:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rd0_q, rd1_q;
  logic [1:0]  req;

  assign req = {bus.m1_req, bus.m0_req};

  // Round-robin: on contention the master that did not win last time goes.
  always_comb begin
    rr_win = (req == 2'b11) ? ~last : req[1];
  end

`ifdef MMIO_ARB_LOCK_EN
  logic       locked;
  logic [1:0] lock;

  assign lock = {bus.m1_lock, bus.m0_lock};

  // A locked owner that is still requesting overrides round-robin.
  always_comb begin
    win = rr_win;
    if (locked && req[owner]) win = owner;
  end

  // Set the lock at the owner's ACK. Drop it once the owner is granted
  // without lock, or when the owner has no request in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      locked <= 1'b0;
    end else if (state == ACK) begin
      if (lock[owner]) locked <= 1'b1;
    end else if (state == IDLE && locked) begin
      if (!req[owner] || !lock[owner]) locked <= 1'b0;
    end
  end
`else
  // Pure round-robin.
  always_comb begin
    win = rr_win;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and decode of the strobes, acks and busy.
  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    bus.mmio_cs = 1'b0;
    bus.mmio_wr = 1'b0;
    bus.mmio_rd = 1'b0;
    bus.m0_ack  = 1'b0;
    bus.m1_ack  = 1'b0;
    bus.busy    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        bus.mmio_cs = 1'b1;
        bus.mmio_wr = wr_q;
        bus.mmio_rd = ~wr_q;
        bus.busy    = 1'b1;
        state_nxt   = ACK;
      end
      ACK: begin
        bus.m0_ack = ~owner;
        bus.m1_ack = owner;
        bus.busy   = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's command at grant. Capture read data at the end of ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner   <= 1'b0;
      last    <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      if (grant) begin
        owner   <= win;
        last    <= win;
        wr_q    <= win ? bus.m1_wr      : bus.m0_wr;
        addr_q  <= win ? bus.m1_addr    : bus.m0_addr;
        wdata_q <= win ? bus.m1_wr_data : bus.m0_wr_data;
      end
      if (state == ISSUE && !wr_q) begin
        if (owner) rd1_q <= bus.mmio_rd_data;
        else       rd0_q <= bus.mmio_rd_data;
      end
    end
  end

  assign bus.mmio_addr    = addr_q;
  assign bus.mmio_wr_data = wdata_q;
  assign bus.m0_rd_data   = rd0_q;
  assign bus.m1_rd_data   = rd1_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Scoreboard bench for mmio_arbiter. A transaction-level model predicts the
// bus strobe and ack for every grant. A negedge monitor compares them with
// what the DUT shows.
module tb_mmio_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mmio_arbiter_if bif();

  mmio_arbiter dut (.clk(clk), .reset(reset), .bus(bif.slave));

  // Bus slot: read data is a combinational function of the address.
  function automatic logic [31:0] rd_val(input logic [20:0] a);
    if (a == 21'h40) return 32'hDEADBEEF;
    return {a[10:0], a} ^ 32'hA5C3_0F1E;
  endfunction

  assign bif.mmio_rd_data = rd_val(bif.mmio_addr);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int cyc; logic wr; logic [20:0] addr; logic [31:0] data; } bus_t;
  typedef struct { int cyc; int m; logic [31:0] rd0; logic [31:0] rd1; } ack_t;

  bus_t        bq[$];
  ack_t        aq[$];
  int          ack_order[$];
  int          ecnt = 0;
  int          free_at = 0;
  bit          last_m = 1'b1;
  logic [20:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] rd_m [2];
  bit          locked_m = 1'b0;
  int          lown = 0;
  int          lock_edge = -1;

  // A grant is possible at an edge three edges after the previous grant.
  // Its strobe is visible after that edge and its ack one edge later.
  always @(posedge clk) begin
    bit   r0, r1;
    int   w;
    logic wr;
    logic [20:0] a;
    logic [31:0] d;
    ecnt++;
    r0 = bif.m0_req;
    r1 = bif.m1_req;
    if (reset) begin
      bq.delete();
      aq.delete();
      free_at   = ecnt + 1;
      last_m    = 1'b1;
      m_addr    = '0;
      m_wdata   = '0;
      rd_m[0]   = '0;
      rd_m[1]   = '0;
      locked_m  = 1'b0;
      lock_edge = -1;
    end else begin
`ifdef MMIO_ARB_LOCK_EN
      if (ecnt == lock_edge && (lown == 1 ? bif.m1_lock : bif.m0_lock)) locked_m = 1'b1;
`endif
      if (ecnt >= free_at && (r0 || r1)) begin
        w = (r0 && r1) ? int'(!last_m) : int'(r1);
`ifdef MMIO_ARB_LOCK_EN
        if (locked_m) begin
          if (lown == 1 ? r1 : r0) begin
            w = lown;
            if (!(lown == 1 ? bif.m1_lock : bif.m0_lock)) locked_m = 1'b0;
          end else begin
            locked_m = 1'b0;
          end
        end
`endif
        last_m = (w == 1);
        lown   = w;
        wr = (w == 1) ? bif.m1_wr      : bif.m0_wr;
        a  = (w == 1) ? bif.m1_addr    : bif.m0_addr;
        d  = (w == 1) ? bif.m1_wr_data : bif.m0_wr_data;
        m_addr  = a;
        m_wdata = d;
        if (!wr) rd_m[w] = rd_val(a);
        bq.push_back('{ecnt, wr, a, d});
        aq.push_back('{ecnt + 1, w, rd_m[0], rd_m[1]});
        free_at   = ecnt + 3;
        lock_edge = ecnt + 2;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    bit exp_cs, exp_ack;
    int em;
    exp_cs = (bq.size() > 0) && (bq[0].cyc == ecnt);
    chk("mmio_cs", bif.mmio_cs, exp_cs);
    if (exp_cs) begin
      chk("mmio_wr", bif.mmio_wr, bq[0].wr);
      chk("mmio_rd", bif.mmio_rd, !bq[0].wr);
      chk("mmio_addr", bif.mmio_addr, bq[0].addr);
      chk("mmio_wr_data", bif.mmio_wr_data, bq[0].data);
      void'(bq.pop_front());
    end else begin
      chk("mmio_wr_idle", bif.mmio_wr, 0);
      chk("mmio_rd_idle", bif.mmio_rd, 0);
    end
    chk("addr_hold", bif.mmio_addr, m_addr);
    chk("wdata_hold", bif.mmio_wr_data, m_wdata);
    exp_ack = (aq.size() > 0) && (aq[0].cyc == ecnt);
    em = exp_ack ? aq[0].m : -1;
    chk("m0_ack", bif.m0_ack, em == 0);
    chk("m1_ack", bif.m1_ack, em == 1);
    if (exp_ack) begin
      chk("m0_rd_data", bif.m0_rd_data, aq[0].rd0);
      chk("m1_rd_data", bif.m1_rd_data, aq[0].rd1);
      void'(aq.pop_front());
    end
    chk("busy", bif.busy, ecnt < free_at - 1);
    if (bif.m0_ack) ack_order.push_back(0);
    if (bif.m1_ack) ack_order.push_back(1);
  end

  // ---------------- stimulus ----------------
  // Called at posedge+#1 (or at a negedge). Holds the request until the ack,
  // then returns in the following IDLE cycle with req still high.
  task automatic drive(input int m, input bit wr, input logic [20:0] a, input logic [31:0] d);
    int  n;
    bit  got;
    if (m == 0) begin
      bif.m0_req = 1'b1; bif.m0_wr = wr; bif.m0_addr = a; bif.m0_wr_data = d;
    end else begin
      bif.m1_req = 1'b1; bif.m1_wr = wr; bif.m1_addr = a; bif.m1_wr_data = d;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      got = (m == 0) ? bif.m0_ack : bif.m1_ack;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: master %0d got no ack, required one within 60 cycles", m);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_order(input string nm, input int exp[$]);
    chk({nm, "_count"}, ack_order.size(), exp.size());
    for (int i = 0; i < exp.size() && i < ack_order.size(); i++)
      chk(nm, ack_order[i], exp[i]);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bif.m0_req = 0; bif.m0_wr = 0; bif.m0_addr = '0; bif.m0_wr_data = '0;
    bif.m1_req = 0; bif.m1_wr = 0; bif.m1_addr = '0; bif.m1_wr_data = '0;
`ifdef MMIO_ARB_LOCK_EN
    bif.m0_lock = 0; bif.m1_lock = 0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", bif.busy, 0);
    chk("rst_cs", bif.mmio_cs, 0);
    chk("rst_acks", {bif.m0_ack, bif.m1_ack}, 0);
    chk("rst_addr", bif.mmio_addr, 0);
    chk("rst_wdata", bif.mmio_wr_data, 0);
    chk("rst_rd0", bif.m0_rd_data, 0);
    chk("rst_rd1", bif.m1_rd_data, 0);

    // Single read by m0, then a single write by m1.
    drive(0, 1'b0, 21'h000040, 32'h0);
    bif.m0_req = 0;
    chk("read_data", bif.m0_rd_data, 32'hDEADBEEF);
    drive(1, 1'b1, 21'h000082, 32'h12345678);
    bif.m1_req = 0;
    chk("write_keeps_rd1", bif.m1_rd_data, 0);
    repeat (2) begin @(posedge clk); #1; end

    // Reset in the ISSUE cycle of an m1 read: no ack, and m0 then wins contention.
    bif.m1_req = 1; bif.m1_wr = 0; bif.m1_addr = 21'h001234;
    n = 0;
    do begin @(negedge clk); n++; end while (!bif.mmio_cs && n < 20);
    chk("rst_issue_seen", bif.mmio_cs, 1);
    reset = 1'b1;
    bif.m1_req = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_m1_ack", bif.m1_ack, 0);
    chk("abort_cs", bif.mmio_cs, 0);
    chk("abort_busy", bif.busy, 0);
    ack_order.delete();
    fork
      drive(0, 1'b0, 21'h000100, 32'h0);
      drive(1, 1'b1, 21'h000104, 32'hCAFEF00D);
    join
    bif.m0_req = 0; bif.m1_req = 0;
    chk_order("contention_order", '{0, 1});

    // Late request: m1 raises req during m0's ISSUE cycle.
    ack_order.delete();
    fork
      drive(0, 1'b1, 21'h000200, 32'h0BADBEEF);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!bif.mmio_cs && n < 20);
        drive(1, 1'b0, 21'h000204, 32'h0);
      end
    join
    bif.m0_req = 0; bif.m1_req = 0;
    chk_order("late_order", '{0, 1});

    // Lock: m1 starts one cycle ahead, m0 then requests continuously.
    ack_order.delete();
`ifdef MMIO_ARB_LOCK_EN
    bif.m1_lock = 1;
`endif
    fork
      begin
        for (int i = 0; i < 3; i++) drive(1, i[0], 21'h000300 + 21'(i), 32'h100 + i);
        bif.m1_req = 0;
`ifdef MMIO_ARB_LOCK_EN
        bif.m1_lock = 0;
`endif
      end
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) drive(0, 1'b0, 21'h000400 + 21'(i), 32'h0);
        bif.m0_req = 0;
      end
    join
`ifdef MMIO_ARB_LOCK_EN
    chk_order("lock_order", '{1, 1, 1, 0, 0, 0});
`else
    chk_order("lock_order", '{1, 0, 1, 0, 1, 0});
`endif

    // Random traffic from both masters.
    fork
      for (int i = 0; i < 30; i++) begin
        int g;
        g = $urandom_range(0, 3);
        if (g > 0) begin
          bif.m0_req = 0;
          repeat (g) begin @(posedge clk); #1; end
        end
`ifdef MMIO_ARB_LOCK_EN
        bif.m0_lock = ($urandom_range(0, 3) == 0);
`endif
        drive(0, $urandom_range(0, 1) == 1, 21'($urandom), $urandom);
      end
      for (int j = 0; j < 30; j++) begin
        int g;
        g = $urandom_range(0, 3);
        if (g > 0) begin
          bif.m1_req = 0;
          repeat (g) begin @(posedge clk); #1; end
        end
`ifdef MMIO_ARB_LOCK_EN
        bif.m1_lock = ($urandom_range(0, 3) == 0);
`endif
        drive(1, $urandom_range(0, 1) == 1, 21'($urandom), $urandom);
      end
    join
    bif.m0_req = 0; bif.m1_req = 0;
`ifdef MMIO_ARB_LOCK_EN
    bif.m0_lock = 0; bif.m1_lock = 0;
`endif
    repeat (6) @(posedge clk);
    #1;
    chk("scoreboard_drained", bq.size() + aq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
